// File: rtl/x16_pkg.sv
// Shared definitions for the X16 memory arbiter and address translator:
// CPU region limits, physical region prefixes and the arbiter state encoding.
package x16_pkg;

    localparam int PHYS_W = 22;

    localparam logic [15:0] LOW_RAM_BASE = 16'h0002;
    localparam logic [15:0] LOW_RAM_END  = 16'h9EFF;
    localparam logic [15:0] IO_BASE      = 16'h9F00;
    localparam logic [15:0] HI_RAM_BASE  = 16'hA000;
    localparam logic [15:0] ROM_BASE     = 16'hC000;

    localparam logic [5:0] LOW_PREFIX = 6'b000000;
    localparam logic [1:0] HI_PREFIX  = 2'b01;
    localparam logic [1:0] ROM_PREFIX = 2'b10;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_LOW,
        REGION_HI,
        REGION_ROM
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_LDR
    } arb_state_t;

endpackage

// File: rtl/x16_addr_xlate.sv
// Combinational CPU region decode and physical address build through the
// ram_bank / rom_bank registers; also used by the debugger.
module x16_addr_xlate
    import x16_pkg::*;
#(
    parameter int MEM_AW        = 22,
    parameter int PHYS_HI_BANKS = 128
) (
    input  logic [15:0]       addr,
    input  logic              we,
    input  logic [7:0]        ram_bank,
    input  logic [7:0]        rom_bank,
    output logic [MEM_AW-1:0] phys_addr,
    output logic              mem_access,
    output logic              bad_read
);

    region_t           region;
    logic [PHYS_W-1:0] phys;
    logic              hi_ok;
    logic              unused_bits;

    always_comb begin
        region = REGION_NONE;
        if (addr >= ROM_BASE)
            region = REGION_ROM;
        else if (addr >= HI_RAM_BASE)
            region = REGION_HI;
        else if (addr >= IO_BASE)
            region = REGION_NONE;
        else if (addr >= LOW_RAM_BASE && addr <= LOW_RAM_END)
            region = REGION_LOW;
    end

    always_comb begin
        phys = '0;
        case (region)
            REGION_LOW: phys = {LOW_PREFIX, addr};
            REGION_HI:  phys = {HI_PREFIX, ram_bank[6:0], addr[12:0]};
            REGION_ROM: phys = {ROM_PREFIX, rom_bank[5:0], addr[13:0]};
            default:    phys = '0;
        endcase
    end

    // The full 8-bit bank register is compared so bank 0x80+ never aliases.
    assign hi_ok = (32'(ram_bank) < PHYS_HI_BANKS);

    assign phys_addr  = MEM_AW'(phys);
    assign mem_access = (region == REGION_LOW)
                      || (region == REGION_HI && hi_ok)
                      || (region == REGION_ROM && !we);
    assign bad_read   = (region == REGION_HI) && !hi_ok && !we;

    assign unused_bits = ^rom_bank[7:6];

endmodule

// File: rtl/x16_mem_arbiter.sv
// Arbitrates the external memory port between the 65C02 bus and the image
// loader. The loader path exists only when X16_LOADER_EN is defined.
module x16_mem_arbiter
    import x16_pkg::*;
#(
    parameter int MEM_AW        = 22,
    parameter int PHYS_HI_BANKS = 128
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_strobe,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dout,
    input  logic [7:0]        ram_bank,
    input  logic [7:0]        rom_bank,
    output logic              cpu_rdy,
    output logic [7:0]        cpu_rdata,
    input  logic              ldr_req,
    input  logic [MEM_AW-1:0] ldr_addr,
    input  logic [7:0]        ldr_data,
    output logic              ldr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              cpu_pending;
    logic [15:0]       addr_q;
    logic              we_q;
    logic [7:0]        dout_q;
    logic              accept;
    logic [15:0]       xl_addr;
    logic              xl_we;
    logic [MEM_AW-1:0] phys_addr;
    logic              mem_access;
    logic              bad_read;
    logic              cpu_done;

    assign accept  = cpu_strobe && !cpu_pending;
    // During the strobe cycle decode the live bus; afterwards the latched one.
    assign xl_addr = accept ? cpu_addr : addr_q;
    assign xl_we   = accept ? cpu_we   : we_q;

    x16_addr_xlate #(
        .MEM_AW        (MEM_AW),
        .PHYS_HI_BANKS (PHYS_HI_BANKS)
    ) u_xlate (
        .addr       (xl_addr),
        .we         (xl_we),
        .ram_bank   (ram_bank),
        .rom_bank   (rom_bank),
        .phys_addr  (phys_addr),
        .mem_access (mem_access),
        .bad_read   (bad_read)
    );

    assign cpu_rdy  = !cpu_pending && !(cpu_strobe && (mem_access || bad_read));
    assign cpu_done = (state == ST_CPU) && mem_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cpu_pending <= 1'b0;
            cpu_rdata   <= 8'h00;
        end else begin
            state <= state_next;
            if (accept && mem_access)
                cpu_pending <= 1'b1;
            else if (cpu_done)
                cpu_pending <= 1'b0;
            // Out-of-range hi-RAM reads finish after the strobe-cycle stall.
            if (accept && bad_read)
                cpu_rdata <= 8'hFF;
            else if (cpu_done && !we_q)
                cpu_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (accept && mem_access) begin
            addr_q <= cpu_addr;
            we_q   <= cpu_we;
            dout_q <= cpu_dout;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
`ifdef X16_LOADER_EN
                if (ldr_req)
                    state_next = ST_LDR;
                else
`endif
                if (cpu_pending || (accept && mem_access))
                    state_next = ST_CPU;
            end
            ST_CPU: begin
                if (mem_ack)
                    state_next = ST_IDLE;
            end
`ifdef X16_LOADER_EN
            ST_LDR: begin
                if (mem_ack)
                    state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        ldr_ack   = 1'b0;
        case (state)
            ST_CPU: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = phys_addr;
                mem_wdata = dout_q;
            end
`ifdef X16_LOADER_EN
            ST_LDR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ldr_addr;
                mem_wdata = ldr_data;
                ldr_ack   = mem_ack;
            end
`endif
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

`ifndef X16_LOADER_EN
    logic unused_ldr;
    assign unused_ldr = ^{ldr_req, ldr_addr, ldr_data};
`endif

endmodule
